// File: rtl/pac_move_ctrl.sv
// Pac-Man sprite movement sequencer: buffered turns against maze walls,
// tunnel wrap on x, clamp on y, and mouth animation, paced by frame ticks.
module pac_move_ctrl #(
   parameter int unsigned X_START   = 320,
   parameter int unsigned Y_START   = 240,
   parameter int unsigned STEP      = 2,
   parameter int unsigned MOVE_DIV  = 1,
   parameter int unsigned MOUTH_DIV = 8,
   parameter int unsigned X_MIN     = 16,
   parameter int unsigned X_MAX     = 624,
   parameter int unsigned Y_MIN     = 16,
   parameter int unsigned Y_MAX     = 464
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        btn_up,
   input  logic        btn_left,
   input  logic        btn_down,
   input  logic        btn_right,
   input  logic        wall_up,
   input  logic        wall_left,
   input  logic        wall_down,
   input  logic        wall_right,
   output logic [31:0] pos1,
   output logic [31:0] pos2,
   output logic        up,
   output logic        left,
   output logic        down,
   output logic        right,
   output logic        moving,
   output logic        moved
);

   typedef enum logic {ST_STOP, ST_MOVING} state_e;

   localparam logic [1:0]  D_RIGHT = 2'd0;
   localparam logic [1:0]  D_UP    = 2'd1;
   localparam logic [1:0]  D_LEFT  = 2'd2;
   localparam logic [1:0]  D_DOWN  = 2'd3;

   localparam logic [31:0] STEP_W     = 32'(STEP);
   localparam logic [31:0] X_MIN_W    = 32'(X_MIN);
   localparam logic [31:0] X_MAX_W    = 32'(X_MAX);
   localparam logic [31:0] Y_MIN_W    = 32'(Y_MIN);
   localparam logic [31:0] Y_MAX_W    = 32'(Y_MAX);
   localparam logic [31:0] MOVE_LAST  = 32'(MOVE_DIV - 1);
   localparam logic [31:0] MOUTH_LAST = 32'(MOUTH_DIV - 1);

   state_e      state_q, state_d;
   logic [31:0] pos1_q, pos1_d;
   logic [31:0] pos2_q, pos2_d;
   logic [1:0]  dir_q, dir_d;
   logic        req_valid_q, req_valid_d;
   logic [1:0]  req_dir_q, req_dir_d;
   logic [31:0] move_cnt_q, move_cnt_d;
   logic [31:0] mouth_cnt_q, mouth_cnt_d;
   logic        mouth_open_q, mouth_open_d;
   logic        moved_q, moved_d;
   logic [3:0]  wedge_q, wedge_d;

   logic [3:0]  wall_v;
   logic        step;
   logic        sel_req;
   logic        sel_keep;
   logic        clamp;
   logic [1:0]  move_dir;

   assign wall_v   = {wall_down, wall_left, wall_up, wall_right};
   assign step     = frame_tick && (move_cnt_q == MOVE_LAST);
   assign sel_req  = step && req_valid_q && !wall_v[req_dir_q];
   assign sel_keep = step && !sel_req && (state_q == ST_MOVING)
                     && !wall_v[dir_q];
   assign move_dir = sel_req ? req_dir_q : dir_q;

   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_STOP;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_STOP: begin
            if (sel_req && !clamp) state_d = ST_MOVING;
         end
         ST_MOVING: begin
            if (step && (!(sel_req || sel_keep) || clamp))
               state_d = ST_STOP;
         end
         default: state_d = ST_STOP;
      endcase
   end

   always_comb begin
      pos1_d      = pos1_q;
      pos2_d      = pos2_q;
      dir_d       = dir_q;
      req_valid_d = req_valid_q;
      req_dir_d   = req_dir_q;
      move_cnt_d  = move_cnt_q;
      mouth_cnt_d = mouth_cnt_q;
      mouth_open_d = mouth_open_q;
      clamp       = 1'b0;

      if (frame_tick)
         move_cnt_d = step ? 32'd0 : move_cnt_q + 32'd1;

      if (sel_req) begin
         dir_d       = req_dir_q;
         req_valid_d = 1'b0;
      end

      // Compare before subtracting so edge positions never underflow.
      if (sel_req || sel_keep) begin
         unique case (move_dir)
            D_RIGHT: pos1_d = (pos1_q + STEP_W > X_MAX_W) ?
                              X_MIN_W : pos1_q + STEP_W;
            D_LEFT:  pos1_d = (pos1_q < X_MIN_W + STEP_W) ?
                              X_MAX_W : pos1_q - STEP_W;
            D_UP: begin
               if (pos2_q < Y_MIN_W + STEP_W) begin
                  pos2_d = Y_MIN_W;
                  clamp  = 1'b1;
               end else begin
                  pos2_d = pos2_q - STEP_W;
               end
            end
            D_DOWN: begin
               if (pos2_q + STEP_W > Y_MAX_W) begin
                  pos2_d = Y_MAX_W;
                  clamp  = 1'b1;
               end else begin
                  pos2_d = pos2_q + STEP_W;
               end
            end
            default: ;
         endcase
      end

      if (btn_up) begin
         req_valid_d = 1'b1;
         req_dir_d   = D_UP;
      end else if (btn_down) begin
         req_valid_d = 1'b1;
         req_dir_d   = D_DOWN;
      end else if (btn_left) begin
         req_valid_d = 1'b1;
         req_dir_d   = D_LEFT;
      end else if (btn_right) begin
         req_valid_d = 1'b1;
         req_dir_d   = D_RIGHT;
      end

      if (state_d == ST_STOP) begin
         mouth_open_d = 1'b1;
         mouth_cnt_d  = 32'd0;
      end else if (state_q == ST_MOVING && frame_tick) begin
         if (mouth_cnt_q == MOUTH_LAST) begin
            mouth_cnt_d  = 32'd0;
            mouth_open_d = !mouth_open_q;
         end else begin
            mouth_cnt_d = mouth_cnt_q + 32'd1;
         end
      end

      moved_d = (pos1_d != pos1_q) || (pos2_d != pos2_q);
      wedge_d = mouth_open_d ? (4'b0001 << dir_d) : 4'b0000;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pos1_q       <= 32'(X_START);
         pos2_q       <= 32'(Y_START);
         dir_q        <= D_LEFT;
         req_valid_q  <= 1'b0;
         req_dir_q    <= D_LEFT;
         move_cnt_q   <= 32'd0;
         mouth_cnt_q  <= 32'd0;
         mouth_open_q <= 1'b1;
         moved_q      <= 1'b0;
         wedge_q      <= 4'b0100;
      end else begin
         pos1_q       <= pos1_d;
         pos2_q       <= pos2_d;
         dir_q        <= dir_d;
         req_valid_q  <= req_valid_d;
         req_dir_q    <= req_dir_d;
         move_cnt_q   <= move_cnt_d;
         mouth_cnt_q  <= mouth_cnt_d;
         mouth_open_q <= mouth_open_d;
         moved_q      <= moved_d;
         wedge_q      <= wedge_d;
      end
   end

   always_comb begin
      pos1   = pos1_q;
      pos2   = pos2_q;
      right  = wedge_q[0];
      up     = wedge_q[1];
      left   = wedge_q[2];
      down   = wedge_q[3];
      moving = (state_q == ST_MOVING);
      moved  = moved_q;
   end

endmodule

// File: tb/tb_pac_move_ctrl.sv
// Directed and random bench for pac_move_ctrl against a behavioural
// model of sprite motion, wrap/clamp and mouth animation.
module tb_pac_move_ctrl;

   localparam int X_START = 320, Y_START = 240, STEP = 2;
   localparam int MOVE_DIV = 1, MOUTH_DIV = 8;
   localparam int X_MIN = 16, X_MAX = 624, Y_MIN = 16, Y_MAX = 464;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        frame_tick = 1'b0;
   logic        btn_up = 1'b0, btn_left = 1'b0;
   logic        btn_down = 1'b0, btn_right = 1'b0;
   logic        wall_up = 1'b0, wall_left = 1'b0;
   logic        wall_down = 1'b0, wall_right = 1'b0;
   logic [31:0] pos1, pos2;
   logic        up, left, down, right, moving, moved;

   int errors = 0;
   int checks = 0;

   // model state; direction 0=R 1=U 2=L 3=D
   int m_x, m_y, m_dir, m_req_dir, m_tick_cnt, m_mouth_ticks;
   bit m_mov, m_req, m_open, m_moved;
   int dx[4] = '{STEP, 0, -STEP, 0};
   int dy[4] = '{0, -STEP, 0, STEP};

   pac_move_ctrl dut (
      .clock(clock), .reset(reset), .frame_tick(frame_tick),
      .btn_up(btn_up), .btn_left(btn_left),
      .btn_down(btn_down), .btn_right(btn_right),
      .wall_up(wall_up), .wall_left(wall_left),
      .wall_down(wall_down), .wall_right(wall_right),
      .pos1(pos1), .pos2(pos2),
      .up(up), .left(left), .down(down), .right(right),
      .moving(moving), .moved(moved)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_x = X_START; m_y = Y_START; m_dir = 2; m_req = 0;
      m_req_dir = 0; m_mov = 0; m_tick_cnt = 0;
      m_mouth_ticks = 0; m_open = 1; m_moved = 0;
   endtask

   task automatic model_clock();
      bit step, was_mov, stop_clamp;
      bit [3:0] w;
      int d, nx, ny;
      if (reset) begin
         model_reset();
         return;
      end
      w = {wall_down, wall_left, wall_up, wall_right};
      was_mov = m_mov;
      step = 0;
      if (frame_tick) begin
         m_tick_cnt++;
         if (m_tick_cnt == MOVE_DIV) begin
            m_tick_cnt = 0;
            step = 1;
         end
      end
      m_moved = 0;
      if (step) begin
         d = -1;
         if (m_req && !w[m_req_dir]) begin
            m_dir = m_req_dir; m_req = 0; m_mov = 1; d = m_dir;
         end else if (m_mov && !w[m_dir]) begin
            d = m_dir;
         end else begin
            m_mov = 0;
         end
         if (d >= 0) begin
            nx = m_x + dx[d];
            ny = m_y + dy[d];
            stop_clamp = 0;
            if (nx > X_MAX) nx = X_MIN;
            if (nx < X_MIN) nx = X_MAX;
            if (ny < Y_MIN) begin ny = Y_MIN; stop_clamp = 1; end
            if (ny > Y_MAX) begin ny = Y_MAX; stop_clamp = 1; end
            if (stop_clamp) m_mov = 0;
            m_moved = (nx != m_x) || (ny != m_y);
            m_x = nx;
            m_y = ny;
         end
      end
      if (!m_mov) begin
         m_open = 1;
         m_mouth_ticks = 0;
      end else if (was_mov && frame_tick) begin
         m_mouth_ticks++;
         if (m_mouth_ticks == MOUTH_DIV) begin
            m_mouth_ticks = 0;
            m_open = !m_open;
         end
      end
      if (btn_up)         begin m_req = 1; m_req_dir = 1; end
      else if (btn_down)  begin m_req = 1; m_req_dir = 3; end
      else if (btn_left)  begin m_req = 1; m_req_dir = 2; end
      else if (btn_right) begin m_req = 1; m_req_dir = 0; end
   endtask

   task automatic cycle();
      logic [3:0] exp_w;
      @(posedge clock);
      model_clock();
      #1;
      exp_w = m_open ? (4'b0001 << m_dir) : 4'b0000;
      chk("pos1", pos1, m_x);
      chk("pos2", pos2, m_y);
      chk("wedge", {28'd0, down, left, up, right}, {28'd0, exp_w});
      chk("moving", {31'd0, moving}, {31'd0, m_mov});
      chk("moved", {31'd0, moved}, {31'd0, m_moved});
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         cycle();
         frame_tick = 1'b0;
         cycle();
      end
   endtask

   task automatic press(input int d);
      btn_right = (d == 0); btn_up = (d == 1);
      btn_left = (d == 2); btn_down = (d == 3);
      cycle();
      {btn_up, btn_left, btn_down, btn_right} = 4'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      model_reset();
      do_reset();
      cycle();
      chk("rst_pos1", pos1, 320);
      chk("rst_pos2", pos2, 240);
      chk("rst_left", {31'd0, left}, 1);

      // right for three steps
      press(0);
      ticks(3);
      chk("right3_pos1", pos1, 326);
      chk("right3_dir", {31'd0, right}, 1);
      ticks(10);

      // wall ahead stops and opens the mouth
      wall_right = 1'b1;
      ticks(1);
      chk("wall_stop", {31'd0, moving}, 0);
      chk("wall_right", {31'd0, right}, 1);
      wall_right = 1'b0;

      // buffered turn
      do_reset();
      press(2);
      ticks(1);
      wall_up = 1'b1;
      press(1);
      ticks(4);
      chk("buf_pos1", pos1, 310);
      wall_up = 1'b0;
      ticks(1);
      chk("buf_pos2", pos2, 238);
      chk("buf_up", {31'd0, up}, 1);

      // reset coincident with a tick mid-move
      reset = 1'b1;
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      reset = 1'b0;
      chk("rst_mid_pos2", pos2, 240);
      chk("rst_mid_mov", {31'd0, moving}, 0);
      cycle();

      // tunnel wrap both ways
      press(0);
      ticks(152);
      chk("wrap_pre", pos1, 624);
      ticks(1);
      chk("wrap_r", pos1, 16);
      press(2);
      ticks(1);
      chk("wrap_l", pos1, 624);

      // top clamp
      press(1);
      ticks(120);
      chk("clamp_top", pos2, 16);
      ticks(2);
      press(3);
      ticks(230);
      chk("clamp_bot", pos2, 464);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 499) == 0);
         frame_tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0)
            {btn_up, btn_left, btn_down, btn_right} = 4'($urandom);
         else
            {btn_up, btn_left, btn_down, btn_right} = 4'b0;
         {wall_up, wall_left, wall_down, wall_right} =
            4'($urandom) & 4'($urandom);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pac_move_ctrl.md
Name: pac_move_ctrl

Overview:
Sequences the Pac-Man sprite for the circle/wedge renderer. It owns the sprite centre position (pos1 = x, pos2 = y) and the four one-hot mouth-direction lines (up/left/down/right). Once per movement step it applies buffered joystick turns against maze wall flags. It also animates the mouth open/closed. It sits between the button/maze-lookup logic and the sprite renderer, and advances only on the VGA frame tick.

Parameters:
X_START, 320, reset x position
Y_START, 240, reset y position
STEP, 2, pixels moved per movement step
MOVE_DIV, 1, frame ticks per movement step (>=1)
MOUTH_DIV, 8, frame ticks per mouth open/closed toggle (>=1)
X_MIN, 16, left tunnel edge (x wrap target)
X_MAX, 624, right tunnel edge (x wrap target)
Y_MIN, 16, top clamp
Y_MAX, 464, bottom clamp

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
btn_up, btn_left, btn_down, btn_right  in  1 each  raw direction requests, level
wall_up, wall_left, wall_down, wall_right  in  1 each  a step of STEP from the current pos in that direction hits a wall; valid every cycle
pos1  out  32  sprite centre x, unsigned
pos2  out  32  sprite centre y, unsigned
up, left, down, right  out  1 each  mouth-wedge select for the renderer
moving  out  1  state == MOVING
moved  out  1  one-cycle pulse when pos1/pos2 changed

Behaviour:
- Reset (synchronous, active-high): pos1=X_START, pos2=Y_START, dir=LEFT, state=STOP, req_valid=0, move_cnt=0, mouth_cnt=0, mouth_open=1, moved=0. Resulting outputs: left=1, up=down=right=0.
- Reset dominates every other input in the same cycle, including mid-step.
- dir encoding (2 bits): 0=RIGHT, 1=UP, 2=LEFT, 3=DOWN.
- Request latch, every cycle:
  - Any button high sets req_valid=1 and req_dir to that button.
  - Priority when several are high: up > down > left > right.
  - The latch is registered. A button arriving in the same cycle as a step is not seen by that step.
- Step evaluation:
  - On frame_tick, move_cnt increments.
  - When move_cnt == MOVE_DIV-1, move_cnt clears to 0 and a step is evaluated in that cycle.
- Step decision, in priority order:
  1. req_valid and wall[req_dir]==0: dir<=req_dir, req_valid<=0, state<=MOVING, apply move.
  2. Else if state==MOVING and wall[dir]==0: apply move in dir. req_valid stays set (pre-turn buffer).
  3. Else: state<=STOP, position unchanged. A blocked request remains buffered.
- Apply move:
  - RIGHT: if pos1+STEP > X_MAX then pos1<=X_MIN, else pos1+=STEP.
  - LEFT: if pos1 < X_MIN+STEP then pos1<=X_MAX, else pos1-=STEP.
  - UP: if pos2 < Y_MIN+STEP then pos2<=Y_MIN and state<=STOP, else pos2-=STEP.
  - DOWN: if pos2+STEP > Y_MAX then pos2<=Y_MAX and state<=STOP, else pos2+=STEP.
  - All arithmetic is 32-bit unsigned. Compare before subtracting so there is no underflow.
- moved: asserted for exactly the one cycle following a step in which pos1 or pos2 changed value. The new position is visible on that same cycle (one-cycle latency from the evaluating tick). A clamp that leaves the position unchanged gives moved=0.
- Mouth animation:
  - While MOVING, each frame_tick increments mouth_cnt. At MOUTH_DIV-1, mouth_cnt clears and mouth_open toggles.
  - On entry to STOP, mouth_open<=1 and mouth_cnt<=0.
- Outputs:
  - up/left/down/right = onehot(dir) AND mouth_open, registered. At most one is high.
  - All four are 0 when the mouth is closed, so the renderer draws a full disc.
- frame_tick asserted for more than one cycle: each high cycle counts as a tick.

Test Plan:
- Reset with no buttons -> pos=(320,240), left=1, others 0, moving=0, moved=0 on the cycle after reset deasserts.
- btn_right pulse, walls 0, MOVE_DIV=1, then 3 frame_ticks -> pos1 = 322, 324, 326 on successive ticks. moved pulses 3 times. right=1 until mouth toggles after 8 ticks.
- Moving right with wall_right=1 at tick -> state STOP, pos unchanged, moved=0, mouth_open=1, right=1.
- Buffered turn: moving left with btn_up pulse while wall_up=1 for 4 ticks, then wall_up=0 -> pos1 drops 2 per tick for 4 ticks. On the 5th tick dir=UP, pos2 = 240-2 = 238, up=1.
- Wrap: pos1=624 moving right, tick -> pos1=16, moved=1. Then btn_left and 1 tick -> pos1=624.
- Reset asserted on the same cycle as frame_tick mid-move -> no step taken, next-cycle state equals the reset values.
